// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one digit per cycle, LSD first.
// Subtraction uses 9's complement plus carry-in; a negative result is 10's-complemented in CORR.
module bcd_serial_addsub #(
  parameter int unsigned NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] result,
  output logic              cout,
  output logic              neg,
  output logic              err
);

  localparam int unsigned W  = 4 * NDIG;
  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {StIdle, StAdd, StCorr, StDone} state_e;

  state_e        state_q;
  logic [W-1:0]  a_q, b_q;
  logic          mode_q;
  logic          carry_q;
  logic [IW-1:0] idx_q;

  logic [3:0] dig_a, dig_b, dig_bp, dig_r, dig_out;
  logic [4:0] sum;
  logic       carry_out;
  logic       last;
  logic       bad_in;

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (a[i*4 +: 4] > 4'd9 || b[i*4 +: 4] > 4'd9) bad_in = 1'b1;
    end
  end

  // Shared digit adder: ADD computes a + b' + c, CORR computes (9 - r) + c.
  always_comb begin
    dig_a  = a_q[idx_q*4 +: 4];
    dig_b  = b_q[idx_q*4 +: 4];
    dig_r  = result[idx_q*4 +: 4];
    dig_bp = mode_q ? (4'd9 - dig_b) : dig_b;
    if (state_q == StCorr) begin
      sum = 5'(4'd9 - dig_r) + 5'(carry_q);
    end else begin
      sum = 5'(dig_a) + 5'(dig_bp) + 5'(carry_q);
    end
    if (sum > 5'd9) begin
      dig_out   = 4'(sum - 5'd10);
      carry_out = 1'b1;
    end else begin
      dig_out   = sum[3:0];
      carry_out = 1'b0;
    end
    last = (idx_q == IW'(NDIG - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      neg     <= 1'b0;
      err     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            mode_q <= mode;
            cout   <= 1'b0;
            neg    <= 1'b0;
            if (bad_in) begin
              err     <= 1'b1;
              result  <= '0;
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              err     <= 1'b0;
              state_q <= StAdd;
              busy    <= 1'b1;
              idx_q   <= '0;
              carry_q <= mode;
            end
          end
        end
        StAdd: begin
          result[idx_q*4 +: 4] <= dig_out;
          if (last) begin
            idx_q <= '0;
            if (!mode_q || carry_out) begin
              // Subtract with final carry means A >= B: the sum is already the magnitude.
              cout    <= mode_q ? 1'b0 : carry_out;
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_q <= StCorr;
              carry_q <= 1'b1;
            end
          end else begin
            idx_q   <= idx_q + 1'b1;
            carry_q <= carry_out;
          end
        end
        StCorr: begin
          result[idx_q*4 +: 4] <= dig_out;
          if (last) begin
            idx_q   <= '0;
            neg     <= 1'b1;
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            idx_q   <= idx_q + 1'b1;
            carry_q <= carry_out;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed self-checking bench for bcd_serial_addsub (NDIG=4).
module tb_bcd_serial_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [15:0] a, b;
  logic        busy, done, cout, neg, err;
  logic [15:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_serial_addsub #(.NDIG(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .neg    (neg),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Drives one request after a falling edge; lat = rising edges until done (-1 on timeout).
  task automatic do_op(input logic m, input logic [15:0] av, input logic [15:0] bv,
                       output int lat, output int bcnt);
    bit seen = 0;
    @(negedge clk);
    start = 1'b1; mode = m; a = av; b = bv;
    lat = 0; bcnt = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (done) seen = 1;
      else if (busy) bcnt++;
    end
    if (!seen) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({busy, done, cout, neg, err, result} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b_%b_%b_%b_%b_%h want all zero",
               busy, done, cout, neg, err, result);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat, bc;
    do_op(1'b0, 16'h9999, 16'h0001, lat, bc);
    n_tests++;
    if (lat !== 5) begin n_fail++; $display("FAIL add_ovf_lat: got %0d want 5", lat); end
    n_tests++;
    if (result !== 16'h0000 || cout !== 1'b1 || neg !== 1'b0) begin
      n_fail++;
      $display("FAIL add_ovf: got %h c%b n%b want 0000 c1 n0", result, cout, neg);
    end
    do_op(1'b0, 16'h1234, 16'h5678, lat, bc);
    n_tests++;
    if (lat !== 5) begin n_fail++; $display("FAIL add_lat: got %0d want 5", lat); end
    n_tests++;
    if (result !== 16'h6912 || cout !== 1'b0 || neg !== 1'b0) begin
      n_fail++;
      $display("FAIL add: got %h c%b n%b want 6912 c0 n0", result, cout, neg);
    end
    n_tests++;
    if (bc !== 4) begin n_fail++; $display("FAIL add_busy: got %0d want 4", bc); end
    // Outputs must hold after done.
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (result !== 16'h6912 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL add_hold: got %h d%b want 6912 d0", result, done);
    end
  endtask

  task automatic test_sub();
    int lat, bc;
    do_op(1'b1, 16'h5000, 16'h1234, lat, bc);
    n_tests++;
    if (lat !== 5 || result !== 16'h3766 || neg !== 1'b0 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_pos: got lat%0d %h n%b c%b want lat5 3766 n0 c0", lat, result, neg, cout);
    end
    do_op(1'b1, 16'h4321, 16'h4321, lat, bc);
    n_tests++;
    if (lat !== 5 || result !== 16'h0000 || neg !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_eq: got lat%0d %h n%b want lat5 0000 n0", lat, result, neg);
    end
    do_op(1'b1, 16'h0123, 16'h0456, lat, bc);
    n_tests++;
    if (lat !== 9 || result !== 16'h0333 || neg !== 1'b1 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_neg: got lat%0d %h n%b c%b want lat9 0333 n1 c0", lat, result, neg, cout);
    end
    n_tests++;
    if (bc !== 8) begin n_fail++; $display("FAIL sub_neg_busy: got %0d want 8", bc); end
    do_op(1'b1, 16'h0000, 16'h0001, lat, bc);
    n_tests++;
    if (lat !== 9 || result !== 16'h0001 || neg !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_neg1: got lat%0d %h n%b want lat9 0001 n1", lat, result, neg);
    end
    do_op(1'b0, 16'h0200, 16'h0300, lat, bc);
    n_tests++;
    if (result !== 16'h0500 || neg !== 1'b0) begin
      n_fail++;
      $display("FAIL neg_clear: got %h n%b want 0500 n0", result, neg);
    end
  endtask

  task automatic test_err();
    int lat, bc;
    do_op(1'b0, 16'h12A4, 16'h0001, lat, bc);
    n_tests++;
    if (lat !== 1 || err !== 1'b1 || result !== 16'h0000 || cout !== 1'b0 || neg !== 1'b0) begin
      n_fail++;
      $display("FAIL err_a: got lat%0d e%b %h c%b n%b want lat1 e1 0000 c0 n0",
               lat, err, result, cout, neg);
    end
    do_op(1'b1, 16'h0010, 16'h00F0, lat, bc);
    n_tests++;
    if (lat !== 1 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_b: got lat%0d e%b want lat1 e1", lat, err);
    end
    do_op(1'b0, 16'h0001, 16'h0002, lat, bc);
    n_tests++;
    if (lat !== 5 || err !== 1'b0 || result !== 16'h0003) begin
      n_fail++;
      $display("FAIL err_clear: got lat%0d e%b %h want lat5 e0 0003", lat, err, result);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    int dones = 0;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; a = 16'h1111; b = 16'h2222;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, cout, neg, err, result} !== 21'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got %b_%b_%b_%b_%b_%h want all zero",
               busy, done, cout, neg, err, result);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    n_tests++;
    if (dones !== 0) begin n_fail++; $display("FAIL mid_reset_done: got %0d want 0", dones); end
    do_op(1'b0, 16'h0456, 16'h0123, lat, bc);
    n_tests++;
    if (lat !== 5 || result !== 16'h0579) begin
      n_fail++;
      $display("FAIL after_reset: got lat%0d %h want lat5 0579", lat, result);
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0, dbl = 0, bad = 0, lat = -1;
    logic prev = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; a = 16'h1234; b = 16'h5678;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        if (prev) dbl++;
        if (result !== 16'h6912) bad++;
      end
      prev = done;
    end
    start = 1'b0;
    n_tests++;
    if (dones !== 4 || dbl !== 0) begin
      n_fail++;
      $display("FAIL b2b_pulses: got %0d (adjacent %0d) want 4 (adjacent 0)", dones, dbl);
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL b2b_result: got %0d bad want 0", bad); end
    repeat (6) @(posedge clk);
    // A start pulse mid-operation with different operands must be ignored.
    @(negedge clk);
    start = 1'b1; mode = 1'b1; a = 16'h5000; b = 16'h1234;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(posedge clk); #1;
      start = (i == 2);
      if (i == 2) begin mode = 1'b0; a = 16'h9999; b = 16'h9999; end
      if (done) lat = i;
    end
    n_tests++;
    if (lat !== 5 || result !== 16'h3766 || neg !== 1'b0 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start: got lat%0d %h n%b c%b want lat5 3766 n0 c0",
               lat, result, neg, cout);
    end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_idle: got d%b b%b want d0 b0", done, busy);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_err();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
